// File: rtl/src1_fwd_ctrl.sv
// src1_fwd_ctrl: EX-stage ALU/shifter source-1 select and load-use stall.
// Optional macro SRC1_FWD_EN enables the forwarding codes 111/100.
module src1_fwd_ctrl #(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [1:0]        id_src_kind,
  input  logic [REG_AW-1:0] id_src_reg,
  input  logic [REG_AW-1:0] id_dst_reg,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              hold,
  input  logic              flush,
  output logic [2:0]        src1sel,
  output logic              id_stall,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] dst;
    logic              we;
    logic              load;
  } slot_t;

  slot_t             r_s1;
  slot_t             r_s2;
  logic [2:0]        r_sel;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_src_ok;
  logic              w_s1_hit;
  logic              w_s2_hit;
  logic              w_stall;
  logic [2:0]        w_sel_nxt;
  logic              w_cnt_max;
  logic              w_unused;

  assign w_src_ok = id_valid
                  & (id_src_kind == 2'd0)
                  & (id_src_reg != '0);

  assign w_s1_hit = w_src_ok & r_s1.vld & r_s1.we
                  & (r_s1.dst == id_src_reg);
  assign w_s2_hit = w_src_ok & r_s2.vld & r_s2.we
                  & (r_s2.dst == id_src_reg);

`ifdef SRC1_FWD_EN
  // Only a load one stage ahead cannot be forwarded in time
  assign w_stall = w_s1_hit & r_s1.load & ~flush;
`else
  // Without forwarding, wait until the producer reaches WB
  assign w_stall = (w_s1_hit | w_s2_hit) & ~flush;
`endif

  assign w_cnt_max = &r_cnt;

  // Load flags are only partly consumed depending on the build
  assign w_unused = ^{r_s1.load, r_s2.load};

  // Next select: forwarded value first (newest wins), else by source kind
  always_comb begin
    w_sel_nxt = 3'b000;
    unique case (id_src_kind)
      2'd0: w_sel_nxt = 3'b000;
      2'd1: w_sel_nxt = 3'b001;
      2'd2: w_sel_nxt = 3'b010;
      2'd3: w_sel_nxt = 3'b011;
    endcase
`ifdef SRC1_FWD_EN
    if (w_s1_hit) begin
      w_sel_nxt = 3'b111;
    end else if (w_s2_hit) begin
      w_sel_nxt = 3'b100;
    end
`endif
  end

  // Slot shift, select register and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_sel <= 3'b000;
      r_cnt <= '0;
    end else if (!hold) begin
      r_s2 <= r_s1;
      if (flush || w_stall || !id_valid) begin
        r_s1  <= '0;
        r_sel <= 3'b000;
      end else begin
        r_s1  <= {1'b1, id_dst_reg, id_we, id_is_load};
        r_sel <= w_sel_nxt;
      end
      if (w_stall && !w_cnt_max) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign src1sel   = r_sel;
  assign id_stall  = w_stall;
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_src1_fwd_ctrl.sv
// tb_src1_fwd_ctrl: pipeline-occupancy model plus directed load-use,
// forwarding, hold, flush, reset and counter-saturation vectors.
module tb_src1_fwd_ctrl;

  localparam int AW = 4;
  localparam int CW = 3;
  localparam int CMAX = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          id_valid = 1'b0;
  logic [1:0]    id_src_kind = 2'd0;
  logic [AW-1:0] id_src_reg = '0;
  logic [AW-1:0] id_dst_reg = '0;
  logic          id_we = 1'b0;
  logic          id_is_load = 1'b0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    src1sel;
  logic          id_stall;
  logic [CW-1:0] stall_cnt;

  int n_run = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  src1_fwd_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src_kind(id_src_kind), .id_src_reg(id_src_reg),
    .id_dst_reg(id_dst_reg), .id_we(id_we),
    .id_is_load(id_is_load), .hold(hold), .flush(flush),
    .src1sel(src1sel), .id_stall(id_stall), .stall_cnt(stall_cnt)
  );

  // ---------------- model: who is in EX and MEM ----------------
  typedef struct {
    bit v;
    int dst;
    bit we;
    bit ld;
  } ins_t;

  ins_t m_ex  = '{0, 0, 0, 0};
  ins_t m_mem = '{0, 0, 0, 0};
  int   m_sel = 0;
  int   m_cnt = 0;

  bit   fwd_en;
  initial begin
`ifdef SRC1_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
  end

  // 1 = youngest producer is in EX, 2 = in MEM, 0 = none
  function automatic int prod_age();
    int s;
    s = int'(id_src_reg);
    if (!id_valid || id_src_kind != 2'd0 || s == 0) return 0;
    if (m_ex.v && m_ex.we && m_ex.dst == s) return 1;
    if (m_mem.v && m_mem.we && m_mem.dst == s) return 2;
    return 0;
  endfunction

  function automatic bit m_stall();
    int a;
    if (flush) return 1'b0;
    a = prod_age();
    if (fwd_en) return (a == 1) && m_ex.ld;
    return a != 0;
  endfunction

  function automatic int m_next();
    int a;
    a = prod_age();
    if (fwd_en && a == 1) return 7;
    if (fwd_en && a == 2) return 4;
    return int'(id_src_kind);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ex  = '{0, 0, 0, 0};
      m_mem = '{0, 0, 0, 0};
      m_sel = 0;
      m_cnt = 0;
    end else if (!hold) begin
      bit st;
      int nx;
      st = m_stall();
      nx = m_next();
      m_mem = m_ex;
      if (flush || st || !id_valid) begin
        m_ex  = '{0, 0, 0, 0};
        m_sel = 0;
      end else begin
        m_ex  = '{1, int'(id_dst_reg), id_we, id_is_load};
        m_sel = nx;
      end
      if (st && m_cnt < CMAX) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_src1sel", int'(src1sel), m_sel);
      chk("cmp_stall_cnt", int'(stall_cnt), m_cnt);
      chk("cmp_id_stall", int'(id_stall), int'(m_stall()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set(input bit v, input int k, input int s,
                     input int d, input bit we, input bit ld);
    id_valid    = v;
    id_src_kind = 2'(k);
    id_src_reg  = AW'(s);
    id_dst_reg  = AW'(d);
    id_we       = we;
    id_is_load  = ld;
  endtask

  task automatic do_reset();
    set(0, 0, 0, 0, 0, 0);
    hold  = 1'b0;
    flush = 1'b0;
    rst   = 1'b1;
    tick();
    rst   = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    chk_en = 1'b1;
    chk("rst_sel", int'(src1sel), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    chk("rst_stall", int'(id_stall), 0);

    // ADD R3 then src R3
    set(1, 0, 1, 3, 1, 0);
    #1 chk("t1_stall0", int'(id_stall), 0);
    tick();
    chk("t1_sel0", int'(src1sel), 0);
    set(1, 0, 3, 4, 1, 0);
    #1;
    if (fwd_en) begin
      chk("t1_stall", int'(id_stall), 0);
      tick();
      chk("t1_sel_ex", int'(src1sel), 7);
    end else begin
      chk("t6_stall_a", int'(id_stall), 1);
      tick();
      chk("t6_cnt1", int'(stall_cnt), 1);
      chk("t6_stall_b", int'(id_stall), 1);
      tick();
      chk("t6_cnt2", int'(stall_cnt), 2);
      chk("t6_stall_c", int'(id_stall), 0);
      tick();
      chk("t6_sel", int'(src1sel), 0);
      chk("t6_cnt_end", int'(stall_cnt), 2);
    end

    // ADD R3, independent, then src R3
    do_reset();
    set(1, 0, 1, 3, 1, 0);
    tick();
    set(1, 0, 2, 6, 1, 0);
    tick();
    set(1, 0, 3, 8, 1, 0);
    #1;
    if (fwd_en) begin
      chk("t2_stall", int'(id_stall), 0);
      tick();
      chk("t2_sel_mem", int'(src1sel), 4);
    end else begin
      chk("t2_stall_nf", int'(id_stall), 1);
      tick();
      chk("t2_stall_nf2", int'(id_stall), 0);
      tick();
      chk("t2_sel_nf", int'(src1sel), 0);
    end

    // LW R5 then src R5
    do_reset();
    set(1, 0, 1, 5, 1, 1);
    tick();
    set(1, 0, 5, 9, 1, 0);
    #1 chk("t3_stall", int'(id_stall), 1);
    tick();
    chk("t3_bubble", int'(src1sel), 0);
    chk("t3_cnt", int'(stall_cnt), 1);
    if (fwd_en) begin
      chk("t3_stall_off", int'(id_stall), 0);
      tick();
      chk("t3_sel_mem", int'(src1sel), 4);
    end else begin
      chk("t3_stall_nf", int'(id_stall), 1);
      tick();
      tick();
      chk("t3_sel_nf", int'(src1sel), 0);
      chk("t3_cnt_nf", int'(stall_cnt), 2);
    end

    // R0 writer and non-register kinds
    do_reset();
    set(1, 0, 2, 0, 1, 0);
    tick();
    set(1, 0, 0, 5, 1, 0);
    #1 chk("t4_r0_stall", int'(id_stall), 0);
    tick();
    chk("t4_r0_sel", int'(src1sel), 0);
    set(1, 3, 5, 6, 1, 0);
    tick();
    chk("t4_pc", int'(src1sel), 3);
    set(1, 2, 6, 7, 1, 0);
    tick();
    chk("t4_imm4", int'(src1sel), 2);
    set(1, 1, 7, 8, 1, 0);
    tick();
    chk("t4_imm8", int'(src1sel), 1);
    set(0, 0, 0, 0, 0, 0);
    tick();
    chk("t4_idle", int'(src1sel), 0);

    // hold during load-use
    do_reset();
    set(1, 1, 0, 5, 1, 1);
    tick();
    set(1, 0, 5, 9, 1, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) flush = 1'b1;
      tick();
      chk("t5_hold_sel", int'(src1sel), 1);
      chk("t5_hold_cnt", int'(stall_cnt), 0);
      flush = 1'b0;
      #1 chk("t5_hold_stall", int'(id_stall), 1);
    end
    hold = 1'b0;
    tick();
    chk("t5_rel_cnt", int'(stall_cnt), 1);
    chk("t5_rel_sel", int'(src1sel), 0);

    // flush with matching source
    do_reset();
    set(1, 0, 1, 3, 1, 0);
    tick();
    set(1, 0, 3, 7, 1, 0);
    flush = 1'b1;
    #1 chk("t5_fl_stall", int'(id_stall), 0);
    tick();
    flush = 1'b0;
    chk("t5_fl_sel", int'(src1sel), 0);
    set(1, 0, 7, 0, 0, 0);
    #1 chk("t5_fl_untracked", int'(id_stall), 0);
    tick();
    chk("t5_fl_sel2", int'(src1sel), 0);

    // asynchronous reset mid-hazard
    set(1, 0, 1, 5, 1, 1);
    tick();
    set(1, 0, 5, 9, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_sel", int'(src1sel), 0);
    chk("rst_mid_cnt", int'(stall_cnt), 0);
    chk("rst_mid_stall", int'(id_stall), 0);
    tick();
    rst = 1'b0;

    // counter saturation
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set(1, 1, 0, 5, 1, 1);
      tick();
      set(1, 0, 5, 9, 1, 0);
      #1;
      for (int j = 0; j < 4 && id_stall; j++) begin
        tick();
      end
      chk("sat_stall_done", int'(id_stall), 0);
      tick();
    end
    chk("sat_cnt", int'(stall_cnt), CMAX);

    set(0, 0, 0, 0, 0, 0);
    tick();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
